// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller at the commit point of the RV pipeline.
// Handles CSR accesses, ECALL/illegal traps, MRET, M-mode interrupts, counters and the MMU enable.
module csr_trap_unit #(
  parameter int unsigned     XLEN        = 64,
  parameter bit              VECTORED_EN = 1'b1,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            irq_mtip,
  input  logic            irq_msip,
  input  logic            irq_meip,
  output logic [XLEN-1:0] rd_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      priv_mode,
  output logic [XLEN-1:0] satp_out,
  output logic            translate_en
);

  localparam logic [2:0] OP_CSRRW   = 3'd1;
  localparam logic [2:0] OP_CSRRS   = 3'd2;
  localparam logic [2:0] OP_CSRRC   = 3'd3;
  localparam logic [2:0] OP_MRET    = 3'd4;
  localparam logic [2:0] OP_ECALL   = 3'd5;
  localparam logic [2:0] OP_ILLEGAL = 3'd6;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_SATP     = 12'h180;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  localparam logic [1:0]      PRIV_M   = 2'b11;
  localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);

  logic [1:0]      priv_q, priv_d;
  logic            st_mie_q, st_mie_d;
  logic            st_mpie_q, st_mpie_d;
  logic [1:0]      st_mpp_q, st_mpp_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] satp_q, satp_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
  logic            xlate_q, xlate_d;

  logic            commit, is_csr_op, csr_hit, irq_ok;
  logic            take_irq, take_exc, do_mret, csr_we, sv_mode;
  logic [XLEN-1:0] mip_val, irq_pend, mstatus_val, csr_rdata, csr_wval, mtvec_base;
  logic [3:0]      irq_code, exc_code;

  // Only the mode bits of mtvec are constrained; the base is stored as written.
  function automatic logic [XLEN-1:0] mtvec_warl(input logic [XLEN-1:0] v);
    mtvec_warl = v & ~(VECTORED_EN ? XLEN'(2) : XLEN'(3));
  endfunction

  assign commit    = valid && !stall;
  assign is_csr_op = (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);

  always_comb begin
    mip_val      = '0;
    mip_val[3]   = irq_msip;
    mip_val[7]   = irq_mtip;
    mip_val[11]  = irq_meip;
    mstatus_val        = '0;
    mstatus_val[3]     = st_mie_q;
    mstatus_val[7]     = st_mpie_q;
    mstatus_val[12:11] = st_mpp_q;
  end

  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = '0;
    case (csr_addr)
      A_MSTATUS:  csr_rdata = mstatus_val;
      A_MIE:      csr_rdata = mie_q;
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MTVAL:    csr_rdata = mtval_q;
      A_MIP:      csr_rdata = mip_val;
      A_SATP:     csr_rdata = satp_q;
      A_MCYCLE:   csr_rdata = mcycle_q;
      A_MINSTRET: csr_rdata = minstret_q;
      default:    csr_hit   = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_CSRRW: csr_wval = wdata;
      OP_CSRRS: csr_wval = csr_rdata | wdata;
      OP_CSRRC: csr_wval = csr_rdata & ~wdata;
      default:  csr_wval = csr_rdata;
    endcase
  end

  assign irq_pend = mie_q & mip_val;
  assign irq_ok   = (priv_q != PRIV_M) || st_mie_q;

  always_comb begin
    if (irq_pend[11])     irq_code = 4'd11;
    else if (irq_pend[3]) irq_code = 4'd3;
    else                  irq_code = 4'd7;
  end

  assign exc_code = (op == OP_ECALL) ? (4'd8 + {2'b00, priv_q}) : 4'd2;

  // Interrupts pre-empt whatever is committing; that instruction is discarded.
  assign take_irq = commit && (irq_pend != '0) && irq_ok;
  assign take_exc = commit && !take_irq &&
                    ((op == OP_ECALL) || (op == OP_ILLEGAL) || (is_csr_op && !csr_hit));
  assign do_mret  = commit && !take_irq && !take_exc && (op == OP_MRET);
  assign csr_we   = commit && !take_irq && !take_exc && is_csr_op;

  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    redirect    = take_irq || take_exc || do_mret;
    redirect_pc = '0;
    if (take_irq && mtvec_q[0]) redirect_pc = mtvec_base + XLEN'({irq_code, 2'b00});
    else if (take_irq || take_exc) redirect_pc = mtvec_base;
    else if (do_mret) redirect_pc = mepc_q;
  end

  always_comb begin
    priv_d     = priv_q;
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    st_mpp_d   = st_mpp_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    satp_d     = satp_q;
    mcycle_d   = mcycle_q + XLEN'(1);
    minstret_d = minstret_q + XLEN'(commit && !take_irq && !take_exc);

    if (take_irq || take_exc) begin
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
      st_mpp_d  = priv_q;
      priv_d    = PRIV_M;
      mepc_d    = pc;
      mtval_d   = '0;
      mcause_d  = take_irq ? {1'b1, (XLEN-1)'(irq_code)} : XLEN'(exc_code);
    end else if (do_mret) begin
      priv_d    = st_mpp_q;
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
      st_mpp_d  = 2'b00;
    end else if (csr_we) begin
      case (csr_addr)
        A_MSTATUS: begin
          st_mie_d  = csr_wval[3];
          st_mpie_d = csr_wval[7];
          st_mpp_d  = (csr_wval[12:11] == PRIV_M) ? PRIV_M : 2'b00;
        end
        A_MIE:      mie_d      = csr_wval & IRQ_MASK;
        A_MTVEC:    mtvec_d    = mtvec_warl(csr_wval);
        A_MSCRATCH: mscratch_d = csr_wval;
        A_MEPC:     mepc_d     = csr_wval;
        A_MCAUSE:   mcause_d   = csr_wval;
        A_MTVAL:    mtval_d    = csr_wval;
        A_SATP:     satp_d     = csr_wval;
        A_MCYCLE:   mcycle_d   = csr_wval;
        A_MINSTRET: minstret_d = csr_wval;
        default:    ;
      endcase
    end
  end

  // The MMU enable follows the landed mode/satp with one register of delay.
  assign sv_mode = (XLEN == 64) ? (satp_q[XLEN-1 -: 4] == 4'h8) : satp_q[XLEN-1];
  assign xlate_d = (priv_q != PRIV_M) && sv_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      priv_q     <= PRIV_M;
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      st_mpp_q   <= 2'b00;
      mie_q      <= '0;
      mtvec_q    <= mtvec_warl(RESET_MTVEC);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      satp_q     <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      xlate_q    <= 1'b0;
    end else begin
      priv_q     <= priv_d;
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      st_mpp_q   <= st_mpp_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      satp_q     <= satp_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      xlate_q    <= xlate_d;
    end
  end

  assign rd_data      = csr_rdata;
  assign priv_mode    = priv_q;
  assign satp_out     = satp_q;
  assign translate_en = xlate_q;

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the RV core.
- Sits at the commit point of the pipeline.
- Handles CSRRW/CSRRS/CSRRC accesses, ECALL, illegal-instruction traps, MRET, and asynchronous machine interrupts (timer, software, external) with direct or vectored mtvec.
- Maintains mcycle/minstret counters and drives the satp-based translate enable to the MMU.

Parameters:
- XLEN, 64, data width; legal values 32 or 64.
- VECTORED_EN, 1, when 1, mtvec.MODE=1 selects vectored interrupt entry; when 0, mtvec[1:0] is forced to 0 (WARL).
- RESET_MTVEC, 0, reset value of mtvec.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; no architectural state update while high (counters excepted)
- valid  in  1  an instruction is at commit this cycle
- pc  in  XLEN  pc of the committing instruction
- op  in  3  0=NONE, 1=CSRRW, 2=CSRRS, 3=CSRRC, 4=MRET, 5=ECALL, 6=ILLEGAL
- csr_addr  in  12  CSR address
- wdata  in  XLEN  rs1 / zimm operand, already zero-extended
- irq_mtip, irq_msip, irq_meip  in  1 each  level interrupt lines
- rd_data  out  XLEN  old CSR value, returned to rd; combinational
- redirect  out  1  flush and jump this cycle
- redirect_pc  out  XLEN  target when redirect=1
- priv_mode  out  2  current privilege mode
- satp_out  out  XLEN  current satp
- translate_en  out  1  registered; 1 when priv_mode!=3 and satp MODE is Sv39 (satp[63:60]=8) for XLEN=64, or satp[31]=1 for XLEN=32

Behaviour:
- Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, satp 0x180, mcycle 0xB00, minstret 0xB02.
- Reset: priv_mode=3; mtvec=RESET_MTVEC; every other CSR=0; redirect=0; translate_en=0.
- A commit event is valid && !stall. All state changes land at the posedge following the event.
- rd_data, redirect and redirect_pc are combinational in the same cycle.
- Priority in one cycle: interrupt > ECALL/ILLEGAL > CSR access/MRET.
- Interrupt pending set P = mie & mip.
  - Take an interrupt when P!=0 and (priv_mode<3 or mstatus.MIE=1), and only on a commit event.
  - The committing instruction is discarded: mepc=pc.
  - Selection order: MEI(11) > MSI(3) > MTI(7).
  - mcause={1, cause}.
- Trap entry (interrupt or exception):
  - mstatus.MPIE<=MIE, MIE<=0, MPP<=priv_mode, priv_mode<=3.
  - redirect=1.
  - redirect_pc = mtvec base, or base+4*cause when the trap is an interrupt and mtvec.MODE=1.
  - Exceptions always use the base address.
- ECALL: mcause=8+priv_mode (U=8, M=11); mtval=0.
- ILLEGAL: mcause=2; mtval=0.
- A CSR op to an unimplemented address is an ILLEGAL trap: mcause=2, no CSR write, rd not written.
- CSR write value:
  - CSRRW: wdata.
  - CSRRS: old|wdata.
  - CSRRC: old&~wdata.
- WARL rules on write:
  - mip bits 3/7/11 are read-only and reflect the irq_* lines; other mip bits read 0.
  - mstatus.MPP write of 1 or 2 stores 0.
  - mtvec[1] is forced to 0; mtvec[0] is forced to 0 if !VECTORED_EN.
- MRET:
  - priv_mode<=MPP; MIE<=MPIE; MPIE<=1; MPP<=0.
  - redirect=1; redirect_pc=mepc.
- Counters:
  - mcycle increments every non-reset cycle, including stalled cycles.
  - minstret increments on each commit event with no trap.
  - A CSR write to a counter overrides that cycle's increment.
  - Both counters wrap at 2^XLEN.
- With stall=1: redirect=0; no CSR, mode or mstatus update.
- reset asserted mid-trap overrides all pending updates.
- translate_en is registered from the post-update mode and satp, so it changes one cycle after the update lands.

Test Plan:
- Reset, then read mtvec (RESET_MTVEC=0x8000_0000) and mstatus -> 0x8000_0000 and 0; priv_mode=3; mcycle=1 one cycle after reset drops.
- CSRRW mtvec=0x1001 with VECTORED_EN=1, then CSRRC mtvec wdata=1 -> reads 0x1001 then 0x1000.
- From priv_mode=0 with pc=0x400, ECALL -> redirect_pc=mtvec, mepc=0x400, mcause=8, MPP=0, priv_mode=3. Then MRET -> redirect_pc=0x400, priv_mode=0.
- Vectored interrupt: mtvec=0x1001, mie.MTIE=1, mstatus.MIE=1, irq_mtip=1 and valid at pc=0x200 -> redirect_pc=0x101C, mcause=0x8000_0000_0000_0007, mepc=0x200, minstret unchanged.
- Simultaneous irq_meip and irq_mtip, both enabled, coincident with an ECALL -> cause 11 taken, ECALL discarded.
- satp=0x8000_0000_0000_0000 in M mode -> translate_en=0. After MRET to U (MPP=0) -> translate_en=1 one cycle later.
- CSRRS to address 0x7C0 -> mcause=2, redirect=1, no write.
- Holding stall=1 with an ECALL -> no state change; mcycle still increments.
